// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU decrypt path: FSM encodings and CRC-16/CCITT constants.
package pmu_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One bit of CRC-16/CCITT, MSB-first, non-reflected.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_blk_fifo.sv
// Synchronous block FIFO with show-ahead read; a push is accepted on a full FIFO when a pop
// happens in the same cycle.
module cfg_blk_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cfg_shift_out.sv
// Serialises plaintext blocks LSB-first into the fabric config chain, then releases the fabric.
// Optional CRC-16 over emitted bits when CFG_SHIFT_CRC_EN is defined (adds crc_o).
module cfg_shift_out
    import pmu_pkg::*;
#(
    parameter int unsigned AES_DATA_WIDTH = 128,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    input  logic [AES_DATA_WIDTH-1:0] blk_data_i,
    input  logic                      blk_valid_i,
    output logic                      blk_ready_o,
    output logic                      tdo,
    output logic                      tck_en,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pwr_up_en,
    output logic                      err_o
`ifdef CFG_SHIFT_CRC_EN
    ,
    output logic [15:0]               crc_o
`endif
);

    localparam int unsigned CntW = $clog2(AES_DATA_WIDTH + 1);

    logic [1:0]                state_q, state_d;
    logic [AES_DATA_WIDTH-1:0] shreg_q, shreg_d, fifo_rdata;
    logic [CntW-1:0]           shcnt_q, shcnt_d;
    logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
    logic                      tdo_d, tck_en_d, done_d, pwr_d, err_d;
    logic                      fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic                      in_shift, start_acc, emit, go_done;

    assign in_shift  = (state_q == StShift);
    assign start_acc = start_i & ~in_shift;
    assign emit      = in_shift & (shcnt_q != '0) & (remaining_q != '0);
    assign go_done   = (start_acc & (len_i == '0)) | (in_shift & (remaining_q == '0));

    // Reload on the same edge the last bit leaves so consecutive blocks run gap-free.
    assign fifo_pop    = in_shift & ~fifo_empty & (remaining_q != '0) &
                         ((shcnt_q == '0) | (emit & (shcnt_q == CntW'(1))));
    assign blk_ready_o = in_shift & (~fifo_full | fifo_pop);
    assign fifo_push   = blk_valid_i & blk_ready_o;
    assign fifo_flush  = start_acc | go_done;
    assign busy_o      = in_shift;

    cfg_blk_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (AES_DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (blk_data_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        shcnt_d     = shcnt_q;
        remaining_d = remaining_q;
        tdo_d       = tdo;
        tck_en_d    = 1'b0;
        done_d      = 1'b0;
        pwr_d       = pwr_up_en;
        err_d       = (err_o & ~start_acc) | (blk_valid_i & ~in_shift);
        if (start_acc) begin
            remaining_d = len_i;
            shcnt_d     = '0;
            if (len_i == '0) begin
                state_d = StDone;
                done_d  = 1'b1;
                pwr_d   = 1'b1;
            end else begin
                state_d = StShift;
                pwr_d   = 1'b0;
            end
        end else if (in_shift) begin
            if (remaining_q == '0) begin
                // Anything still buffered belongs to a partial last block and is dropped.
                state_d = StDone;
                done_d  = 1'b1;
                pwr_d   = 1'b1;
                shcnt_d = '0;
            end else begin
                if (emit) begin
                    tdo_d       = shreg_q[0];
                    tck_en_d    = 1'b1;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    shreg_d     = shreg_q >> 1;
                    shcnt_d     = shcnt_q - CntW'(1);
                end
                if (fifo_pop) begin
                    shreg_d = fifo_rdata;
                    shcnt_d = CntW'(AES_DATA_WIDTH);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            shcnt_q     <= '0;
            remaining_q <= '0;
            tdo         <= 1'b0;
            tck_en      <= 1'b0;
            done_o      <= 1'b0;
            pwr_up_en   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            shcnt_q     <= shcnt_d;
            remaining_q <= remaining_d;
            tdo         <= tdo_d;
            tck_en      <= tck_en_d;
            done_o      <= done_d;
            pwr_up_en   <= pwr_d;
            err_o       <= err_d;
        end
    end

`ifdef CFG_SHIFT_CRC_EN
    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (start_acc) begin
            crc_d = CRC16_INIT;
        end else if (emit) begin
            crc_d = crc16_step(crc_q, shreg_q[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
`endif

endmodule

// File: tb/tb_cfg_shift_out.sv
// Directed bench for cfg_shift_out: checks serial stream, pulse counts, gaps, done/err flags.
// Define CFG_SHIFT_CRC_EN to also check crc_o.
module tb_cfg_shift_out;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  len_in = '0;
    logic [127:0] blk_data = '0;
    logic         blk_valid = 1'b0;
    logic         blk_ready, tdo, tck_en, busy, done, pwr_up_en, err;
`ifdef CFG_SHIFT_CRC_EN
    logic [15:0]  crc;
`endif

    always #5 clk = ~clk;

    cfg_shift_out u_dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .len_i       (len_in),
        .blk_data_i  (blk_data),
        .blk_valid_i (blk_valid),
        .blk_ready_o (blk_ready),
        .tdo         (tdo),
        .tck_en      (tck_en),
        .busy_o      (busy),
        .done_o      (done),
        .pwr_up_en   (pwr_up_en),
        .err_o       (err)
`ifdef CFG_SHIFT_CRC_EN
        ,
        .crc_o       (crc)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor samples 1 time unit after each rising edge; drivers act on falling edges.
    logic         mon_clr = 1'b0;
    logic [511:0] cap_bits = '0;
    int pulses = 0, low_pend = 0, gap_total = 0, done_cnt = 0, cyc = 0;
    int first_cyc = -1, done_cyc = -1;

    always @(posedge clk) begin
        #1;
        if (mon_clr) begin
            pulses = 0; low_pend = 0; gap_total = 0; done_cnt = 0; cyc = 0;
            first_cyc = -1; done_cyc = -1; cap_bits = '0;
        end
        cyc++;
        if (tck_en) begin
            if (pulses > 0) gap_total += low_pend;
            low_pend = 0;
            if (pulses == 0) first_cyc = cyc;
            if (pulses < 512) cap_bits[pulses] = tdo;
            pulses++;
        end else if (pulses > 0) begin
            low_pend++;
        end
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic do_start(input logic [15:0] len);
        start = 1'b1; len_in = len; mon_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; mon_clr = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge after the handshake.
    task automatic send_block(input logic [127:0] d);
        int n = 0;
        blk_data = d; blk_valid = 1'b1;
        while (!blk_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("blk_handshake", {31'b0, blk_ready}, 1);
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq(tag, done_cnt, 1);
    endtask

    task automatic wait_pulses(input string tag, input int target);
        int n = 0;
        while (pulses < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, pulses, target);
    endtask

    task automatic check_stream(input string tag, input logic [511:0] exp, input int nbits);
        int mism = 0;
        for (int i = 0; i < nbits; i++) begin
            if (cap_bits[i] !== exp[i]) mism++;
        end
        check_eq(tag, mism, 0);
    endtask

`ifdef CFG_SHIFT_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [127:0] data, input int nbits);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < nbits; i++) begin
            c = c ^ {data[i], 15'b0};
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    localparam logic [127:0] B0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] B1 = 128'hDEAD_BEEF_CAFE_F00D_A5A5_5A5A_0F0F_F0F0;
    localparam logic [127:0] B2 = 128'h8000_0000_0000_0001_1234_5678_9ABC_DEF1;

    initial begin
        logic [511:0] exp_s;
        exp_s = {256'b0, B1, B0};

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_tdo", {31'b0, tdo}, 0);
        check_eq("rst_tck_en", {31'b0, tck_en}, 0);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_pwr_up_en", {31'b0, pwr_up_en}, 0);
        check_eq("rst_err", {31'b0, err}, 0);
        check_eq("rst_ready", {31'b0, blk_ready}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Block offered in IDLE: refused and flagged, flag is sticky
        blk_data = B0; blk_valid = 1'b1;
        check_eq("idle_ready", {31'b0, blk_ready}, 0);
        @(negedge clk);
        blk_valid = 1'b0;
        check_eq("idle_err", {31'b0, err}, 1);
        @(negedge clk);
        check_eq("idle_err_sticky", {31'b0, err}, 1);

        // 256 bits, two back-to-back blocks
        do_start(16'd256);
        check_eq("t1_err_cleared", {31'b0, err}, 0);
        check_eq("t1_busy", {31'b0, busy}, 1);
        send_block(B0);
        send_block(B1);
        wait_done("t1_done_once");
        check_eq("t1_pulses", pulses, 256);
        check_eq("t1_gaps", gap_total, 0);
        check_stream("t1_data", exp_s, 256);
        check_eq("t1_done_cycle", done_cyc - first_cyc, 256);
        check_eq("t1_pwr_up_en", {31'b0, pwr_up_en}, 1);
        check_eq("t1_busy_low", {31'b0, busy}, 0);
        check_eq("t1_err", {31'b0, err}, 0);

        // 200 bits: second block truncated
        do_start(16'd200);
        check_eq("t2_pwr_dropped", {31'b0, pwr_up_en}, 0);
        send_block(B0);
        send_block(B1);
        wait_done("t2_done_once");
        check_eq("t2_pulses", pulses, 200);
        check_stream("t2_data", exp_s, 200);
        check_eq("t2_pwr_up_en", {31'b0, pwr_up_en}, 1);

        // Valid withheld so the chain idles exactly 5 cycles between blocks
        do_start(16'd256);
        send_block(B0);
        wait_pulses("t3_first_block", 128);
        repeat (3) @(negedge clk);
        send_block(B1);
        wait_done("t3_done_once");
        check_eq("t3_pulses", pulses, 256);
        check_eq("t3_gap", gap_total, 5);
        check_stream("t3_data", exp_s, 256);

        // Zero-length load
        do_start(16'd0);
        check_eq("t4_done_pulse", {31'b0, done}, 1);
        check_eq("t4_pwr_up_en", {31'b0, pwr_up_en}, 1);
        check_eq("t4_busy", {31'b0, busy}, 0);
        @(negedge clk);
        check_eq("t4_done_low", {31'b0, done}, 0);
        repeat (2) @(negedge clk);
        check_eq("t4_done_count", done_cnt, 1);
        check_eq("t4_pulses", pulses, 0);

        // Reset at bit 60 of a 128-bit load, then a clean reload
        do_start(16'd128);
        send_block(B2);
        wait_pulses("t5_bit60", 60);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_outs_zero", {25'b0, tdo, tck_en, busy, done, pwr_up_en, err, blk_ready}, 0);
        check_eq("t5_no_more_bits", pulses, 60);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_idle_pwr", {31'b0, pwr_up_en}, 0);
        do_start(16'd128);
        send_block(B2);
        wait_done("t5_done_once");
        check_eq("t5_pulses", pulses, 128);
        check_stream("t5_data", {384'b0, B2}, 128);
        check_eq("t5_pwr_up_en", {31'b0, pwr_up_en}, 1);

`ifdef CFG_SHIFT_CRC_EN
        do_start(16'd128);
        send_block(128'h0);
        wait_done("crc_done_once");
        check_eq("crc_zero_block", {16'b0, crc}, {16'b0, crc_ref(128'h0, 128)});
        do_start(16'd100);
        send_block(B0);
        wait_done("crc2_done_once");
        check_eq("crc_partial_b0", {16'b0, crc}, {16'b0, crc_ref(B0, 100)});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
